seg_scan_mux: RTL and testbench

Time-multiplexed 7-segment display driver that sits directly downstream of the per-digit segment decoders. It takes NUM_DIGITS 8-bit segment patterns (a..g, dp, already polarity-adjusted by the decoder's Type) and drives one shared segment bus plus one-hot digit anodes. Each digit is shown in turn, with a blanking gap between digits to prevent ghosting. Segment data is latched once per digit slot, so patterns never tear mid-slot.

---
 rtl/seg_scan_mux.sv | 117 +++++++++++
 tb/tb_seg_scan_mux.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scan driver: one shared segment bus, one-hot anodes, blanking gap between digits.
// Latency: all outputs registered; a digit's pattern is latched on the BLANK->SHOW edge and visible the next cycle.
// Backpressure: none; En=0 freezes state and outputs, and FrameDone reads 0 while frozen.
module seg_scan_mux #(
   parameter int NUM_DIGITS    = 4,
   parameter int PRESCALE      = 1000,
   parameter int BLANK_CYCLES  = 2,
   parameter bit AN_ACTIVE_LOW = 1'b1
) (
   input  logic                          CLK,
   input  logic                          Reset,
   input  logic                          En,
   input  logic                          Type,
   input  logic [8*NUM_DIGITS-1:0]       SegIn,
   input  logic [NUM_DIGITS-1:0]         DigitEn,
   output logic [7:0]                    SEG,
   output logic [NUM_DIGITS-1:0]         AN,
   output logic [$clog2(NUM_DIGITS)-1:0] DigitSel,
   output logic                          FrameDone
);

   // Counter covers the longer of the two phases.
   localparam int CMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int IW   = $clog2(NUM_DIGITS);

   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   // Level that drives every anode inactive.
   localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   state_t                 state_q;
   logic [CW-1:0]          cnt_q;
   logic [CW-1:0]          cnt_d;
   logic [IW-1:0]          idx_q;
   logic [IW-1:0]          idx_d;
   logic                   idx_last;
   logic [7:0]             seg_q;
   logic [NUM_DIGITS-1:0]  an_q;
   logic                   frame_done_q;
   logic [NUM_DIGITS-1:0]  onehot;
   logic [7:0]             seg_sel;

   // Next-count, wrapping digit index (explicit compare so non-power-of-2 counts never reach NUM_DIGITS), and slot data mux.
   always_comb begin
      cnt_d    = cnt_q + 1'b1;
      idx_last = (idx_q == IDX_LAST);
      idx_d    = idx_last ? '0 : idx_q + 1'b1;
      onehot   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
      seg_sel  = SegIn[8*idx_q +: 8];
   end

   // Scan FSM with registered segment/anode/frame outputs; reset wins over En.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q      <= ST_BLANK;
         cnt_q        <= '0;
         idx_q        <= '0;
         seg_q        <= {8{Type}};
         an_q         <= AN_OFF;
         frame_done_q <= 1'b0;
      end else if (!En) begin
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            ST_BLANK: begin
               an_q  <= AN_OFF;
               seg_q <= {8{Type}};
               if (cnt_q == BLANK_LAST) begin
                  state_q <= ST_SHOW;
                  cnt_q   <= '0;
                  // Disabled digits spend their slot dark rather than being skipped, keeping frame timing fixed.
                  if (DigitEn[idx_q]) begin
                     seg_q <= seg_sel;
                     an_q  <= onehot ^ AN_OFF;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_SHOW: begin
               // Segment/anode registers hold the values latched at slot start.
               if (cnt_q == SHOW_LAST) begin
                  state_q      <= ST_BLANK;
                  cnt_q        <= '0;
                  an_q         <= AN_OFF;
                  seg_q        <= {8{Type}};
                  idx_q        <= idx_d;
                  frame_done_q <= idx_last;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q <= ST_BLANK;
               cnt_q   <= '0;
               an_q    <= AN_OFF;
               seg_q   <= {8{Type}};
            end
         endcase
      end
   end

   assign SEG       = seg_q;
   assign AN        = an_q;
   assign DigitSel  = idx_q;
   assign FrameDone = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: 4-digit and 3-digit instances, PRESCALE=4, BLANK_CYCLES=1, active-low anodes.
// Cycle n after reset release is the output state after n-1 enabled clock edges.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_seg_scan_mux;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic        En = 1'b0;
   logic        Type = 1'b0;
   logic [31:0] SegIn = 32'h804F5B06;
   logic [3:0]  DigitEn = 4'hF;
   logic [7:0]  SEG;
   logic [3:0]  AN;
   logic [1:0]  DigitSel;
   logic        FrameDone;

   logic [23:0] SegIn3 = 24'h4F5B06;
   logic [2:0]  DigitEn3 = 3'b111;
   logic [7:0]  SEG3;
   logic [2:0]  AN3;
   logic [1:0]  DigitSel3;
   logic        FrameDone3;

   int n_cmp = 0;
   int n_bad = 0;

   seg_scan_mux #(.NUM_DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .AN_ACTIVE_LOW(1'b1)) u_dut4 (
      .CLK(CLK), .Reset(Reset), .En(En), .Type(Type), .SegIn(SegIn), .DigitEn(DigitEn),
      .SEG(SEG), .AN(AN), .DigitSel(DigitSel), .FrameDone(FrameDone)
   );

   seg_scan_mux #(.NUM_DIGITS(3), .PRESCALE(4), .BLANK_CYCLES(1), .AN_ACTIVE_LOW(1'b1)) u_dut3 (
      .CLK(CLK), .Reset(Reset), .En(En), .Type(Type), .SegIn(SegIn3), .DigitEn(DigitEn3),
      .SEG(SEG3), .AN(AN3), .DigitSel(DigitSel3), .FrameDone(FrameDone3)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Two reset cycles, then release with En=1; on return the outputs show cycle 1.
   task automatic do_reset();
      Reset = 1'b1;
      En    = 1'b0;
      tick();
      tick();
      Reset = 1'b0;
      En    = 1'b1;
   endtask

   task automatic test_reset();
      Type = 1'b0; SegIn = 32'h804F5B06; DigitEn = 4'hF;
      do_reset();
      n_cmp++; if (AN !== 4'hF)       begin n_bad++; $display("FAIL reset_an got=%b exp=1111", AN); end
      n_cmp++; if (SEG !== 8'h00)     begin n_bad++; $display("FAIL reset_seg got=%h exp=00", SEG); end
      n_cmp++; if (DigitSel !== 2'd0) begin n_bad++; $display("FAIL reset_sel got=%0d exp=0", DigitSel); end
      n_cmp++; if (FrameDone !== 1'b0) begin n_bad++; $display("FAIL reset_fd got=%b exp=0", FrameDone); end
      n_cmp++; if (AN3 !== 3'b111)    begin n_bad++; $display("FAIL reset_an3 got=%b exp=111", AN3); end
   endtask

   // Cycles 1..21 of a frame: slot = 5 cycles (1 blank + 4 lit), digit k lit at cycles 5k+2..5k+5.
   task automatic scan_frame(input string tag);
      logic [7:0] pat [4];
      logic [3:0] one, exp_an;
      logic [7:0] exp_seg;
      logic       exp_fd, lit;
      int         pos, slot;
      for (int k = 0; k < 4; k++) pat[k] = SegIn[8*k +: 8];
      for (int c = 1; c <= 21; c++) begin
         if (c > 1) tick();
         pos     = (c - 1) % 20;
         slot    = pos / 5;
         lit     = (pos % 5 != 0) && DigitEn[slot];
         one     = 4'b0001 << slot;
         exp_an  = lit ? ~one : 4'hF;
         exp_seg = lit ? pat[slot] : {8{Type}};
         exp_fd  = (c > 1) && (pos == 0);
         n_cmp++; if (AN !== exp_an)     begin n_bad++; $display("FAIL %s_an c=%0d got=%b exp=%b", tag, c, AN, exp_an); end
         n_cmp++; if (SEG !== exp_seg)   begin n_bad++; $display("FAIL %s_seg c=%0d got=%h exp=%h", tag, c, SEG, exp_seg); end
         n_cmp++; if (DigitSel !== slot[1:0]) begin n_bad++; $display("FAIL %s_sel c=%0d got=%0d exp=%0d", tag, c, DigitSel, slot); end
         n_cmp++; if (FrameDone !== exp_fd) begin n_bad++; $display("FAIL %s_fd c=%0d got=%b exp=%b", tag, c, FrameDone, exp_fd); end
      end
   endtask

   task automatic test_basic_scan();
      Type = 1'b0; SegIn = 32'h804F5B06; DigitEn = 4'hF;
      do_reset();
      scan_frame("basic");
   endtask

   task automatic test_latching();
      Type = 1'b0; SegIn = 32'h804F5B06; DigitEn = 4'hF;
      do_reset();
      tick(); tick();                 // cycle 3, digit 0 lit
      SegIn[7:0] = 8'h3F;
      for (int c = 3; c <= 5; c++) begin
         if (c > 3) tick();
         n_cmp++; if (SEG !== 8'h06) begin n_bad++; $display("FAIL latch_hold c=%0d got=%h exp=06", c, SEG); end
         n_cmp++; if (AN !== 4'b1110) begin n_bad++; $display("FAIL latch_an c=%0d got=%b exp=1110", c, AN); end
      end
      for (int c = 6; c <= 22; c++) tick();
      n_cmp++; if (SEG !== 8'h3F)  begin n_bad++; $display("FAIL latch_new got=%h exp=3F", SEG); end
      n_cmp++; if (AN !== 4'b1110) begin n_bad++; $display("FAIL latch_new_an got=%b exp=1110", AN); end
   endtask

   task automatic test_blank_polarity();
      Type = 1'b1; SegIn = 32'h804F5B06; DigitEn = 4'b1101;
      do_reset();
      scan_frame("blankpol");
   endtask

   task automatic test_freeze();
      Type = 1'b0; SegIn = 32'h804F5B06; DigitEn = 4'hF;
      do_reset();
      tick(); tick(); tick();         // cycle 4, digit 0 with cnt=2
      En = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++; if (AN !== 4'b1110)    begin n_bad++; $display("FAIL frz_an i=%0d got=%b exp=1110", i, AN); end
         n_cmp++; if (SEG !== 8'h06)     begin n_bad++; $display("FAIL frz_seg i=%0d got=%h exp=06", i, SEG); end
         n_cmp++; if (DigitSel !== 2'd0) begin n_bad++; $display("FAIL frz_sel i=%0d got=%0d exp=0", i, DigitSel); end
      end
      En = 1'b1;
      tick();
      n_cmp++; if (AN !== 4'b1110) begin n_bad++; $display("FAIL frz_last_lit got=%b exp=1110", AN); end
      tick();
      n_cmp++; if (AN !== 4'hF)       begin n_bad++; $display("FAIL frz_blank got=%b exp=1111", AN); end
      n_cmp++; if (DigitSel !== 2'd1) begin n_bad++; $display("FAIL frz_next_sel got=%0d exp=1", DigitSel); end
   endtask

   // Continues from the blank that ends the frozen digit-0 slot.
   task automatic test_reset_mid();
      for (int i = 0; i < 6; i++) tick();   // digit 1 slot, blank, first digit 2 lit cycle
      n_cmp++; if (AN !== 4'b1011) begin n_bad++; $display("FAIL rmid_pre got=%b exp=1011", AN); end
      Reset = 1'b1;
      tick();
      n_cmp++; if (AN !== 4'hF)        begin n_bad++; $display("FAIL rmid_an got=%b exp=1111", AN); end
      n_cmp++; if (DigitSel !== 2'd0)  begin n_bad++; $display("FAIL rmid_sel got=%0d exp=0", DigitSel); end
      n_cmp++; if (FrameDone !== 1'b0) begin n_bad++; $display("FAIL rmid_fd got=%b exp=0", FrameDone); end
      Reset = 1'b0;
      scan_frame("rmid");
   endtask

   task automatic test_non_pow2();
      logic [7:0] pat [3];
      logic [2:0] one, exp_an;
      logic [7:0] exp_seg;
      logic       exp_fd, lit;
      int         pos, slot, pulses;
      Type = 1'b0; SegIn3 = 24'h4F5B06; DigitEn3 = 3'b111;
      for (int k = 0; k < 3; k++) pat[k] = SegIn3[8*k +: 8];
      pulses = 0;
      do_reset();
      for (int c = 1; c <= 31; c++) begin
         if (c > 1) tick();
         pos     = (c - 1) % 15;
         slot    = pos / 5;
         lit     = (pos % 5 != 0);
         one     = 3'b001 << slot;
         exp_an  = lit ? ~one : 3'b111;
         exp_seg = lit ? pat[slot] : 8'h00;
         exp_fd  = (c > 1) && (pos == 0);
         if (FrameDone3 === 1'b1) pulses++;
         n_cmp++; if (DigitSel3 !== slot[1:0]) begin n_bad++; $display("FAIL np2_sel c=%0d got=%0d exp=%0d", c, DigitSel3, slot); end
         n_cmp++; if (FrameDone3 !== exp_fd)   begin n_bad++; $display("FAIL np2_fd c=%0d got=%b exp=%b", c, FrameDone3, exp_fd); end
         n_cmp++; if (AN3 !== exp_an)          begin n_bad++; $display("FAIL np2_an c=%0d got=%b exp=%b", c, AN3, exp_an); end
         n_cmp++; if (SEG3 !== exp_seg)        begin n_bad++; $display("FAIL np2_seg c=%0d got=%h exp=%h", c, SEG3, exp_seg); end
      end
      n_cmp++; if (pulses != 2) begin n_bad++; $display("FAIL np2_pulses got=%0d exp=2", pulses); end
   endtask

   initial begin
      test_reset();
      test_basic_scan();
      test_latching();
      test_blank_polarity();
      test_freeze();
      test_reset_mid();
      test_non_pow2();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
